// File: rtl/mpi_bus_master_if.sv
// mpi_bus_master_if: requester handshake and pad-ring signals of the MPI bus master
// Requester side: req/we/bsel/addr0/addr1/wdata0/wdata1 into the master, gnt/done/err/rdata out.
// Pad side: nAD_o/nAD_oe/nSYNC_o/nDIN_o/nDOUT_o/nWTBT_o/ctrl_oe/sync_oe/nBSY_o out, nAD_i/nRPLY_i in.
interface mpi_bus_master_if;
  logic [1:0] req, we, bsel, gnt, done;
  logic [15:0] addr0, addr1, wdata0, wdata1, rdata, nAD_o, nAD_i;
  logic err, nAD_oe, nSYNC_o, nDIN_o, nDOUT_o, nWTBT_o, ctrl_oe, sync_oe, nBSY_o, nRPLY_i;
  modport master (
    input req, we, bsel, addr0, addr1, wdata0, wdata1, nAD_i, nRPLY_i,
    output gnt, done, err, rdata, nAD_o, nAD_oe, nSYNC_o, nDIN_o, nDOUT_o, nWTBT_o,
      ctrl_oe, sync_oe, nBSY_o
  );
  modport slave (
    output req, we, bsel, addr0, addr1, wdata0, wdata1, nAD_i, nRPLY_i,
    input gnt, done, err, rdata, nAD_o, nAD_oe, nSYNC_o, nDIN_o, nDOUT_o, nWTBT_o,
      ctrl_oe, sync_oe, nBSY_o
  );
endinterface

// File: rtl/mpi_bus_master.sv
// mpi_bus_master: two-port bus-cycle sequencer for the BK MPI bus with an nRPLY timeout
// Ports: CLKp clock (rising edge), nRSTp asynchronous active-low reset,
//   bus (mpi_bus_master_if.master): requester req/we/bsel/addr*/wdata* -> gnt/done/err/rdata,
//   pad drive values and enables nAD_o/nAD_oe/nSYNC_o/nDIN_o/nDOUT_o/nWTBT_o/ctrl_oe/sync_oe/nBSY_o,
//   pad samples nAD_i/nRPLY_i.
// Define MPI_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mpi_bus_master #(
  parameter int TMO_CYC = 64,
  parameter int TMO_W = 7
) (
  input logic CLKp,
  input logic nRSTp,
  mpi_bus_master_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_SYNC, S_AEND, S_DATA, S_WAIT, S_RREL, S_REL, S_END
  } state_t;
  state_t state, state_nx;
  logic [1:0] gnt, win, rply_q;
  logic [TMO_W-1:0] cnt;
  logic [15:0] addr, wdata, rdata;
  logic tmo, rply, tmo_hit, we, bsel, req_any;
  logic adr_ph, wr_ph, strobe, ctrl_oe, sync_oe;
  assign req_any = |bus.req;
  assign we = gnt[1] ? bus.we[1] : bus.we[0];
  assign bsel = gnt[1] ? bus.bsel[1] : bus.bsel[0];
  assign addr = gnt[1] ? bus.addr1 : bus.addr0;
  assign wdata = gnt[1] ? bus.wdata1 : bus.wdata0;
  assign rply = rply_q[1];
  assign tmo_hit = cnt == TMO_W'(TMO_CYC - 1);
`ifdef MPI_RR_ARB_EN
  // last = 1 means port 1 won the previous arbitration, so port 0 wins next contention
  logic last;
  assign win = &bus.req ? (last ? 2'b01 : 2'b10) : (bus.req[0] ? 2'b01 : 2'b10);
  always_ff @(posedge CLKp or negedge nRSTp)
    if (!nRSTp) last <= 1'b1;
    else if (state == S_IDLE && req_any) last <= win[1];
`else
  assign win = bus.req[0] ? 2'b01 : 2'b10;
`endif
  always_ff @(posedge CLKp or negedge nRSTp)
    if (!nRSTp) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = req_any ? S_ADDR : S_IDLE;
      S_ADDR: state_nx = S_SYNC;
      S_SYNC: state_nx = S_AEND;
      S_AEND: state_nx = S_DATA;
      S_DATA: state_nx = S_WAIT;
      S_WAIT: state_nx = !rply ? S_RREL : tmo_hit ? S_REL : S_WAIT;
      S_RREL: state_nx = rply ? S_REL : S_RREL;
      S_REL: state_nx = S_END;
      default: state_nx = S_IDLE;
    endcase
    adr_ph = state inside {S_ADDR, S_SYNC};
    wr_ph = we && state inside {S_DATA, S_WAIT};
    strobe = state == S_WAIT;
    ctrl_oe = state inside {S_ADDR, S_SYNC, S_AEND, S_DATA, S_WAIT, S_RREL};
    // nSYNC stays enabled through REL so it is actively driven high before release
    sync_oe = state inside {S_SYNC, S_AEND, S_DATA, S_WAIT, S_RREL, S_REL};
    bus.ctrl_oe = ctrl_oe;
    bus.sync_oe = sync_oe;
    bus.nBSY_o = !ctrl_oe;
    bus.nSYNC_o = !(sync_oe && state != S_REL);
    bus.nAD_oe = adr_ph || wr_ph;
    bus.nAD_o = adr_ph ? ~addr : wr_ph ? ~wdata : 16'hFFFF;
    bus.nWTBT_o = adr_ph ? ~we : (strobe && we) ? ~bsel : 1'b1;
    bus.nDIN_o = !(strobe && !we);
    bus.nDOUT_o = !(strobe && we);
    bus.done = gnt & {2{state == S_END}};
    bus.err = tmo && state == S_END;
    bus.gnt = gnt;
    bus.rdata = rdata;
  end
  always_ff @(posedge CLKp or negedge nRSTp)
    if (!nRSTp) begin
      gnt <= '0;
      cnt <= '0;
      tmo <= 1'b0;
      rdata <= '0;
      rply_q <= 2'b11;
    end else begin
      rply_q <= {rply_q[0], bus.nRPLY_i};
      cnt <= state == S_WAIT ? cnt + TMO_W'(1) : '0;
      if (state == S_IDLE && req_any) begin
        gnt <= win;
        tmo <= 1'b0;
      end
      if (state == S_END) gnt <= '0;
      if (state == S_WAIT && rply && tmo_hit) tmo <= 1'b1;
      if (state == S_WAIT && !rply && !we) rdata <= ~bus.nAD_i;
    end
endmodule
